// File: rtl/skin_pkg.sv
// Shared constants, pipeline bundle type and pixel classifier helper
// for the skin-mask morphology stage.
package skin_pkg;

    localparam int PIX_W    = 8;
    localparam int COORD_W  = 11;
    localparam int PIPE_LAT = 3;

    localparam logic [PIX_W-1:0] MASK_ON  = 8'hFF;
    localparam logic [PIX_W-1:0] MASK_OFF = 8'h00;

    // Timing and original-image bundle carried through the delay line.
    typedef struct packed {
        logic             hsyn;
        logic             vsyn;
        logic             de;
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } sync_pix_t;

    // A pixel is skin only when the classifier marked all channels white.
    function automatic logic is_skin(
        input logic [PIX_W-1:0] r,
        input logic [PIX_W-1:0] g,
        input logic [PIX_W-1:0] b
    );
        return (r == MASK_ON) && (g == MASK_ON) && (b == MASK_ON);
    endfunction

endpackage

// File: rtl/skin_line_buffer.sv
// 1-bit line buffer, DEPTH entries, single address, read-before-write.
// Ports: i_clk, i_rst_n, i_we, i_addr, i_din -> o_dout (registered old data).
module skin_line_buffer
    import skin_pkg::*;
#(
    parameter int DEPTH = 1920
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_we,
    input  logic [COORD_W-1:0] i_addr,
    input  logic               i_din,
    output logic               o_dout
);

    localparam int AW = $clog2(DEPTH);

    // Contents are deliberately not reset; stale data is masked upstream.
    logic mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dout <= 1'b0;
        end else begin
            o_dout <= mem[i_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/image_skin_erode.sv
// 3x3 binary erosion of the skin mask (dilation with SKIN_MORPH_DILATE_EN),
// with syncs and original RGB delayed to the same 3-cycle latency.
// Inputs: i_clk, i_rst_n, i_hsyn/i_vsyn/i_de, mask i_r/g/b, i_*_original.
// Outputs: o_hsyn/o_vsyn/o_de, mask o_r/g/b (FF/00), o_*_original.
module image_skin_erode
    import skin_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hsyn,
    input  logic             i_vsyn,
    input  logic             i_de,
    input  logic [PIX_W-1:0] i_r,
    input  logic [PIX_W-1:0] i_g,
    input  logic [PIX_W-1:0] i_b,
    input  logic [PIX_W-1:0] i_r_original,
    input  logic [PIX_W-1:0] i_g_original,
    input  logic [PIX_W-1:0] i_b_original,
    output logic             o_hsyn,
    output logic             o_vsyn,
    output logic             o_de,
    output logic [PIX_W-1:0] o_r,
    output logic [PIX_W-1:0] o_g,
    output logic [PIX_W-1:0] o_b,
    output logic [PIX_W-1:0] o_r_original,
    output logic [PIX_W-1:0] o_g_original,
    output logic [PIX_W-1:0] o_b_original
);

    if (H_ACTIVE < 3 || V_ACTIVE < 3 || H_ACTIVE > 2**COORD_W)
    begin : g_bad_size
        $error("image_skin_erode: unsupported frame size");
    end

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(H_ACTIVE - 1);

    logic               bin;
    logic [COORD_W-1:0] col;
    logic [1:0]         row;
    logic               vsyn_d;
    logic               de_d;

    assign bin = is_skin(i_r, i_g, i_b);

    // col tracks the current pixel; row counts completed lines (sat. 2).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col    <= '0;
            row    <= '0;
            vsyn_d <= 1'b0;
            de_d   <= 1'b0;
        end else begin
            vsyn_d <= i_vsyn;
            de_d   <= i_de;
            if (!i_de || col == COL_LAST) begin
                col <= '0;
            end else begin
                col <= col + 1'b1;
            end
            if (i_vsyn && !vsyn_d) begin
                row <= '0;
            end else if (!i_de && de_d && row != 2'd2) begin
                row <= row + 1'b1;
            end
        end
    end

    logic               lb0_q;
    logic               lb1_q;
    logic               s1_bin;
    logic               s1_de;
    logic [1:0]         s1_row;
    logic [COORD_W-1:0] s1_col;

    // LB0: previous line, written with the current binarised pixel.
    skin_line_buffer #(.DEPTH(H_ACTIVE)) u_lb0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (i_de),
        .i_addr  (col),
        .i_din   (bin),
        .o_dout  (lb0_q)
    );

    // LB1 runs one cycle behind so it can take LB0's registered old value.
    skin_line_buffer #(.DEPTH(H_ACTIVE)) u_lb1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (s1_de),
        .i_addr  (s1_col),
        .i_din   (lb0_q),
        .o_dout  (lb1_q)
    );

    logic               s2_bin;
    logic               s2_up1;
    logic               s2_de;
    logic [1:0]         s2_row;
    logic [COORD_W-1:0] s2_col;
    logic [2:0]         w1;
    logic [2:0]         w2;
    logic [2:0]         colv;
    logic               hit;
    logic [PIX_W-1:0]   mask_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_bin <= 1'b0;
            s1_de  <= 1'b0;
            s1_row <= '0;
            s1_col <= '0;
            s2_bin <= 1'b0;
            s2_up1 <= 1'b0;
            s2_de  <= 1'b0;
            s2_row <= '0;
            s2_col <= '0;
        end else begin
            s1_bin <= bin;
            s1_de  <= i_de;
            s1_row <= row;
            s1_col <= col;
            s2_bin <= s1_bin;
            s2_up1 <= lb0_q;
            s2_de  <= s1_de;
            s2_row <= s1_row;
            s2_col <= s1_col;
        end
    end

    // Column c as {r-2, r-1, r}; rows not yet received read as 0.
    assign colv = {lb1_q & (s2_row == 2'd2),
                   s2_up1 & (s2_row != 2'd0),
                   s2_bin};

`ifdef SKIN_MORPH_DILATE_EN
    assign hit = |{colv,
                   w1 & {3{s2_col >= COORD_W'(1)}},
                   w2 & {3{s2_col >= COORD_W'(2)}}};
`else
    assign hit = (s2_row == 2'd2) && (s2_col >= COORD_W'(2)) &&
                 (&{colv, w1, w2});
`endif

    // w1/w2 hold columns c-1 and c-2; frozen outside active video.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w1     <= '0;
            w2     <= '0;
            mask_q <= MASK_OFF;
        end else begin
            if (s2_de) begin
                w1 <= colv;
                w2 <= w1;
            end
            mask_q <= (s2_de && hit) ? MASK_ON : MASK_OFF;
        end
    end

    sync_pix_t dly [PIPE_LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= '{hsyn: i_hsyn, vsyn: i_vsyn, de: i_de,
                        r: i_r_original, g: i_g_original,
                        b: i_b_original};
            for (int i = 1; i < PIPE_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign o_hsyn       = dly[PIPE_LAT-1].hsyn;
    assign o_vsyn       = dly[PIPE_LAT-1].vsyn;
    assign o_de         = dly[PIPE_LAT-1].de;
    assign o_r_original = dly[PIPE_LAT-1].r;
    assign o_g_original = dly[PIPE_LAT-1].g;
    assign o_b_original = dly[PIPE_LAT-1].b;
    assign o_r          = mask_q;
    assign o_g          = mask_q;
    assign o_b          = mask_q;

endmodule

// File: tb/tb_image_skin_erode.sv
// Randomised self-checking bench for image_skin_erode (H_ACTIVE=8,
// 6-line frames) against a frame-array reference model.
module tb_image_skin_erode;

    localparam int H     = 8;
    localparam int LINES = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hs, vs, de;
    logic [7:0] ir, ig, ib, ro, go, bo;
    logic       o_hsyn, o_vsyn, o_de;
    logic [7:0] o_r, o_g, o_b, o_ro, o_go, o_bo;

    image_skin_erode #(.H_ACTIVE(H), .V_ACTIVE(LINES)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_hsyn       (hs),
        .i_vsyn       (vs),
        .i_de         (de),
        .i_r          (ir),
        .i_g          (ig),
        .i_b          (ib),
        .i_r_original (ro),
        .i_g_original (go),
        .i_b_original (bo),
        .o_hsyn       (o_hsyn),
        .o_vsyn       (o_vsyn),
        .o_de         (o_de),
        .o_r          (o_r),
        .o_g          (o_g),
        .o_b          (o_b),
        .o_r_original (o_ro),
        .o_g_original (o_go),
        .o_b_original (o_bo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       de, hs, vs;
        logic [7:0] m, ro, go, bo;
    } rec_t;

    rec_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   ff_obs  = 0;
    int   rst_left = 0;

    // Reference model state: frame image since last clear, pixel coords.
    bit   hist [0:31][0:H-1];
    int   ln = 0;
    int   cl = 0;
    bit   vs_prev = 0;
    bit   de_prev = 0;

    task automatic model_clear();
        ln = 0; cl = 0; vs_prev = 0; de_prev = 0;
    endtask

    task automatic model_step(input logic d, h, v,
                              input logic [23:0] m,
                              input logic [23:0] org);
        rec_t e;
        bit   bn, hit;
        bn  = (m == 24'hFFFFFF);
        hit = 0;
        if (d) begin
            hist[ln][cl] = bn;
`ifdef SKIN_MORPH_DILATE_EN
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    if (ln >= i && cl >= j && hist[ln-i][cl-j]) hit = 1;
`else
            if (ln >= 2 && cl >= 2) begin
                hit = 1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (!hist[ln-i][cl-j]) hit = 0;
            end
`endif
        end
        e.de = d; e.hs = h; e.vs = v;
        e.m  = hit ? 8'hFF : 8'h00;
        e.ro = org[23:16]; e.go = org[15:8]; e.bo = org[7:0];
        q.push_back(e);
        if (v && !vs_prev) ln = 0;
        else if (!d && de_prev && ln < 31) ln++;
        cl = d ? ((cl == H - 1) ? 0 : cl + 1) : 0;
        vs_prev = v;
        de_prev = d;
    endtask

    task automatic check_out();
        rec_t e, a;
        if (q.size() == 3) begin
            e = q.pop_front();
            a = {o_de, o_hsyn, o_vsyn, o_r, o_ro, o_go, o_bo};
            vectors++;
            if (a !== e || o_g !== e.m || o_b !== e.m) begin
                errors++;
                $display("FAIL pipe t=%0t got de%b hs%b vs%b m=%h/%h/%h o=%h/%h/%h want de%b hs%b vs%b m=%h o=%h/%h/%h",
                         $time, o_de, o_hsyn, o_vsyn, o_r, o_g, o_b,
                         o_ro, o_go, o_bo, e.de, e.hs, e.vs, e.m,
                         e.ro, e.go, e.bo);
            end
            if (o_r === 8'hFF) ff_obs++;
        end
    endtask

    task automatic drive(input logic d, h, v,
                         input logic [23:0] m,
                         input logic [23:0] org,
                         input bit start_rst);
        rec_t z;
        z = '0;
        @(negedge clk);
        check_out();
        if (start_rst) begin
            rst_n = 1'b0;
            #1;
            vectors++;
            if ({o_de, o_hsyn, o_vsyn, o_r, o_g, o_b, o_ro, o_go, o_bo}
                !== 51'd0) begin
                errors++;
                $display("FAIL rst_async got de%b m=%h o=%h/%h/%h want all 0",
                         o_de, o_r, o_ro, o_go, o_bo);
            end
            q.delete();
            q.push_back(z);
            q.push_back(z);
            rst_left = 3;
        end else begin
            rst_n = (rst_left == 0);
        end
        de = d; hs = h; vs = v;
        {ir, ig, ib} = m;
        {ro, go, bo} = org;
        if (rst_left > 0) begin
            q.push_back(z);
            model_clear();
            rst_left--;
        end else begin
            model_step(d, h, v, m, org);
        end
    endtask

    function automatic logic [23:0] non_white();
        case ($urandom_range(0, 3))
            0:       return 24'h000000;
            1:       return 24'hFFFFFE;
            2:       return 24'hFEFFFF;
            default: return 24'hFF00FF;
        endcase
    endfunction

    function automatic logic [23:0] pix(input int mode, input int r,
                                        input int c);
        bit w;
        int k;
        case (mode)
            0: w = 1;
            1: w = (r == 3 && c == 4);
            2: w = (r >= 2 && r <= 4 && c >= 3 && c <= 5);
            3: w = (r == 2 && c == 2);
            default: begin
                k = $urandom_range(0, 15);
                if (k < 12) w = 1;
                else if (k < 15) return non_white();
                else return 24'($urandom);
            end
        endcase
        return w ? 24'hFFFFFF : non_white();
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, 24'($urandom), 24'($urandom), 0);
    endtask

    task automatic run_frame(input int mode, input int rl, input int rc);
        for (int i = 0; i < 2; i++)
            drive(0, 1, 1, 24'($urandom), 24'($urandom), 0);
        for (int r = 0; r < LINES; r++) begin
            for (int c = 0; c < H; c++)
                drive(1, 0, 0, pix(mode, r, c), 24'($urandom),
                      (r == rl && c == rc));
            for (int i = 0; i < 2; i++)
                drive(0, 1, 0, 24'($urandom), 24'($urandom), 0);
        end
    endtask

    task automatic check_count(input string name, input int want);
        vectors++;
        if (ff_obs !== want) begin
            errors++;
            $display("FAIL %s ff_count got %0d want %0d", name, ff_obs, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        de = 0; hs = 0; vs = 0;
        {ir, ig, ib, ro, go, bo} = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({o_de, o_hsyn, o_vsyn, o_r, o_g, o_b, o_ro, o_go, o_bo}
            !== 51'd0) begin
            errors++;
            $display("FAIL reset_state got de%b m=%h o=%h want all 0",
                     o_de, o_r, o_ro);
        end
        idle(4);
    endtask

    task automatic test_all_white();
        ff_obs = 0;
        run_frame(0, -1, -1);
        idle(3);
`ifdef SKIN_MORPH_DILATE_EN
        check_count("all_white", 48);
`else
        check_count("all_white", 24);
`endif
    endtask

    task automatic test_single_pixel();
        ff_obs = 0;
        run_frame(1, -1, -1);
        idle(3);
`ifdef SKIN_MORPH_DILATE_EN
        check_count("single_pixel", 9);
`else
        check_count("single_pixel", 0);
`endif
    endtask

    task automatic test_block();
        ff_obs = 0;
        run_frame(2, -1, -1);
        idle(3);
`ifdef SKIN_MORPH_DILATE_EN
        check_count("block", 20);
`else
        check_count("block", 1);
`endif
    endtask

    task automatic test_corner_pixel();
        ff_obs = 0;
        run_frame(3, -1, -1);
        idle(3);
`ifdef SKIN_MORPH_DILATE_EN
        check_count("corner_pixel", 9);
`else
        check_count("corner_pixel", 0);
`endif
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 5; i++)
            drive(1, 0, 0, pix(4, 0, 0), 24'($urandom), 0);
        drive(1, 0, 0, pix(4, 0, 0), {8'd12, 8'd34, 8'd56}, 0);
        for (int i = 0; i < 3; i++)
            drive(1, 0, 0, pix(4, 0, 0), 24'($urandom), 0);
        vectors++;
        if ({o_ro, o_go, o_bo} !== {8'd12, 8'd34, 8'd56}) begin
            errors++;
            $display("FAIL passthrough got %0d/%0d/%0d want 12/34/56",
                     o_ro, o_go, o_bo);
        end
        idle(3);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++)
            run_frame(4, -1, -1);
        idle(3);
    endtask

    task automatic test_reset_mid_line();
        ff_obs = 0;
        run_frame(0, 4, 6);
        run_frame(0, -1, -1);
        idle(3);
`ifndef SKIN_MORPH_DILATE_EN
        check_count("reset_mid_line", 38);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_all_white();
        test_single_pixel();
        test_block();
        test_corner_pixel();
        test_passthrough();
        test_random();
        test_reset_mid_line();
        test_all_white();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/image_skin_erode.md
Name: image_skin_erode

Overview:
- Binary 3x3 morphological erosion stage for the skin-detection mask.
- Sits between the skin-colour classifier, which emits white 8'hFF / black per pixel, and the skin bounding-box selector.
- Removes isolated false-positive skin pixels so that noise does not inflate the box.
- Carries the original RGB and the sync signals through with matched latency, so the box stage receives aligned mask, original image and timing.

Parameters:
- H_ACTIVE, 1920: active pixels per line; depth of each line buffer.
- V_ACTIVE, 1080: active lines per frame; documentation and bench sizing only.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  reset
- i_hsyn  in  1  line sync
- i_vsyn  in  1  frame sync; rising edge = frame start
- i_de  in  1  active pixel strobe
- i_r, i_g, i_b  in  8 each  classifier mask channels
- i_r_original, i_g_original, i_b_original  in  8 each  original image
- o_hsyn, o_vsyn, o_de  out  1 each  syncs delayed 3 cycles
- o_r, o_g, o_b  out  8 each  eroded mask, 8'hFF or 8'h00 on all three
- o_r_original, o_g_original, o_b_original  out  8 each  original RGB delayed 3 cycles

Interface: reset i_rst_n, asynchronous, active-low; clock i_clk.

Behaviour:
- Reset: every output and every pipeline register goes to 0. Line-buffer contents are not reset; they are don't-care, masked by the row count.
- Binarise: bin = 1 iff i_r == 8'hFF && i_g == 8'hFF && i_b == 8'hFF. Any other value, including partial FF, is 0.
- Column counter col, 11 bit:
  - 0 whenever i_de = 0.
  - Increments on each i_de cycle.
  - Wraps to 0 at H_ACTIVE-1 if i_de stays high.
- Row count row, 2 bit:
  - Cleared on i_vsyn rising edge, detected with a 1-cycle registered copy.
  - Increments on each i_de falling edge; saturates at 2.
- Two 1-bit line buffers, H_ACTIVE deep, addressed by col:
  - Read-before-write each i_de cycle.
  - LB0 holds the previous line and LB1 the line before it.
  - LB0's old value is written into LB1; bin is written into LB0.
- Window: 3x3 shift registers of columns (row r, r-1, r-2), shifted only on i_de.
- Output for the input pixel (r, c) accepted at cycle t is presented at cycle t+3. Its value is the AND of bin(r-i, c-j) for i, j in {0, 1, 2}.
- Out-of-range taps force the result to 0: row < 2 or col < 2 at that pixel. The window is not centred; the box downstream shifts by +1 row / +1 column, which is accepted.
- Cycles with i_de = 0: o_r/o_g/o_b = 0, the window is frozen, and syncs/originals still propagate with 3-cycle delay.
- Latency: fixed 3 cycles for every output, independent of data.
- i_vsyn rising edge mid-line: row is cleared; col is unaffected.
- Reset mid-frame: outputs 0 asynchronously. row = 0 after reset, so the mask stays 0 until two full lines of the next frame have been received.
- A line shorter than H_ACTIVE is legal; unused buffer addresses keep stale data and are never read for valid output.

Optional Feature:
- Macro SKIN_MORPH_DILATE_EN.
- Defined: the window reduction is OR instead of AND (dilation). Out-of-range taps contribute 0, so borders are not forced black; the result is the OR of the in-range taps.
- Undefined: erosion, exactly as above.
- Latency and ports are identical in both builds.

Decomposition:
- Package skin_pkg:
  - PIX_W = 8
  - COORD_W = 11
  - MASK_ON = 8'hFF
  - MASK_OFF = 8'h00
  - PIPE_LAT = 3
- Sub-module skin_line_buffer: 1-bit wide, H_ACTIVE deep, one address, read-before-write, registered read, write enable = i_de.
- Instantiated twice.

Test Plan (H_ACTIVE=8, 6-line frames, i_de continuous within line, 2-cycle blanking):
- All-white frame: o_r/g/b = FF exactly for input pixels with row >= 2 and col >= 2, 0 elsewhere. o_de equals i_de delayed 3 cycles.
- Single white pixel at (3,4) in a black frame: all outputs 0 for the whole frame.
- White 3x3 block at rows 2-4, cols 3-5: exactly one FF output, 3 cycles after input pixel (4,5) is accepted.
- SKIN_MORPH_DILATE_EN defined, single white pixel at (2,2): FF on outputs for input pixels (2..4, 2..4) only; 9 pixels.
- Original passthrough: i_*_original = 12/34/56 on one cycle appears on o_*_original exactly 3 cycles later while the mask changes independently.
- i_rst_n pulsed low mid-line in an all-white frame: outputs 0 immediately. Mask stays 0 for the remainder of that frame and for lines 0-1 of the next frame; FF resumes at next-frame row 2, col 2.
